// File: rtl/alvio_write_ctrl_pkg.sv
// Shared types and sizing for the AL-violation RAM write controller.
package alvio_write_ctrl_pkg;

  localparam int unsigned DEPTH   = 16;  // active-list entries
  localparam int unsigned INDEX   = 4;   // log2(DEPTH)
  localparam int unsigned WIDTH   = 8;   // violation-record width
  localparam int unsigned NUM_REQ = 2;   // request lanes per cycle
  localparam int unsigned Q_DEPTH = 4;   // request queue entries
  localparam int unsigned Q_LOG   = 2;   // log2(Q_DEPTH)

  typedef enum logic {
    ALVIO_INIT,
    ALVIO_RUN
  } alvio_wr_state_t;

  typedef struct packed {
    logic [INDEX-1:0] addr;
    logic [WIDTH-1:0] data;
  } alvioReq_t;

endpackage

// File: rtl/alvio_write_ctrl_if.sv
// Multi-lane violation-update request bus from the disambiguation logic.
interface alvio_write_ctrl_if;
  import alvio_write_ctrl_pkg::*;

  logic [NUM_REQ-1:0]            reqValid_i;
  logic [NUM_REQ-1:0][INDEX-1:0] reqAddr_i;
  logic [NUM_REQ-1:0][WIDTH-1:0] reqData_i;
  logic                          reqReady_o;

  modport master (
    output reqValid_i,
    output reqAddr_i,
    output reqData_i,
    input  reqReady_o
  );

  modport slave (
    input  reqValid_i,
    input  reqAddr_i,
    input  reqData_i,
    output reqReady_o
  );

endinterface

// File: rtl/alvio_write_ctrl_req_fifo.sv
// In-order request queue: several push ports per cycle, one pop port.
// The caller guarantees enough free slots for every asserted push.
module alvio_req_fifo
  import alvio_write_ctrl_pkg::*;
#(
  parameter int unsigned PUSH_PORTS = 2,
  parameter int unsigned ENTRIES    = 4,
  parameter int unsigned PTR_W      = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear_i,
  input  logic [PUSH_PORTS-1:0]      push_i,
  input  alvioReq_t [PUSH_PORTS-1:0] pushData_i,
  input  logic                       pop_i,
  output alvioReq_t                  head_o,
  output logic                       empty_o,
  output logic [PTR_W:0]             count_o
);

  alvioReq_t        mem_q [ENTRIES];
  alvioReq_t        mem_d [ENTRIES];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W:0]   pushCnt;
  logic [PTR_W-1:0] slot;

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Compact active lanes into consecutive slots in lane order; clear wins.
  always_comb begin
    mem_d   = mem_q;
    slot    = '0;
    pushCnt = '0;
    for (int unsigned k = 0; k < PUSH_PORTS; k++) begin
      if (push_i[k]) begin
        slot        = wrPtr_q + pushCnt[PTR_W-1:0];
        mem_d[slot] = pushData_i[k];
        pushCnt     = pushCnt + (PTR_W+1)'(1);
      end
    end
    wrPtr_d = wrPtr_q + pushCnt[PTR_W-1:0];
    rdPtr_d = rdPtr_q + PTR_W'(pop_i);
    count_d = count_q + pushCnt - (PTR_W+1)'(pop_i);
    if (clear_i) begin
      mem_d   = mem_q;
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/alvio_write_ctrl.sv
// AL-violation RAM write controller: zero-sweep after reset, then drain
// queued violation updates through the single RAM write port.
module alvio_write_ctrl
  import alvio_write_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_i,
  alvio_write_ctrl_if.slave        req,
  output logic                     we_o,
  output logic [INDEX-1:0]         addrWr_o,
  output logic [WIDTH-1:0]         dataWr_o,
  output logic                     ready_o,
  output logic [Q_LOG:0]           pending_o
);

  alvio_wr_state_t  state_q, state_d;
  logic [INDEX-1:0] cnt_q, cnt_d;

  alvioReq_t [NUM_REQ-1:0] pushData;
  logic [NUM_REQ-1:0]      push;
  logic                    pop;
  logic                    clear;
  logic                    qEmpty;
  alvioReq_t               qHead;
  logic [Q_LOG:0]          qCount;
  logic [Q_LOG:0]          freeSlots;

  // FSM state and sweep counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ALVIO_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sweep advances one index per cycle and hands over to RUN after the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ALVIO_INIT: begin
        cnt_d = cnt_q + INDEX'(1);
        if (cnt_q == INDEX'(DEPTH - 1)) begin
          state_d = ALVIO_RUN;
        end
      end
      ALVIO_RUN: begin
        state_d = ALVIO_RUN;
      end
      default: state_d = ALVIO_INIT;
    endcase
  end

  // Write-port mux, ready indications and queue control.
  // Reset gates the outputs directly because state_q already reads INIT
  // while reset is held, which would otherwise show a sweep write.
  always_comb begin
    we_o           = 1'b0;
    addrWr_o       = '0;
    dataWr_o       = '0;
    ready_o        = 1'b0;
    req.reqReady_o = 1'b0;
    pop            = 1'b0;
    clear          = 1'b0;
    freeSlots      = (Q_LOG+1)'(Q_DEPTH) - qCount;
    if (!reset) begin
      unique case (state_q)
        ALVIO_INIT: begin
          we_o     = 1'b1;
          addrWr_o = cnt_q;
        end
        ALVIO_RUN: begin
          ready_o        = 1'b1;
          we_o           = !qEmpty && !flush_i;
          addrWr_o       = qHead.addr;
          dataWr_o       = qHead.data;
          pop            = we_o;
          clear          = flush_i;
          req.reqReady_o = (freeSlots >= (Q_LOG+1)'(NUM_REQ));
        end
        default: ;
      endcase
    end
  end

  // Lane qualification and request packing.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      push[k]          = req.reqValid_i[k] && req.reqReady_o && !flush_i;
      pushData[k].addr = req.reqAddr_i[k];
      pushData[k].data = req.reqData_i[k];
    end
  end

  alvio_req_fifo #(
    .PUSH_PORTS (NUM_REQ),
    .ENTRIES    (Q_DEPTH),
    .PTR_W      (Q_LOG)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (clear),
    .push_i     (push),
    .pushData_i (pushData),
    .pop_i      (pop),
    .head_o     (qHead),
    .empty_o    (qEmpty),
    .count_o    (qCount)
  );

  assign pending_o = qCount;

endmodule

// File: tb/tb_alvio_write_ctrl.sv
// Directed bench for the AL-violation RAM write controller.
module tb_alvio_write_ctrl;
  import alvio_write_ctrl_pkg::*;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush_i = 1'b0;
  logic           we_o;
  logic [3:0]     addrWr_o;
  logic [7:0]     dataWr_o;
  logic           ready_o;
  logic [2:0]     pending_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned nz    = 0;
  logic        track = 1'b0;
  logic [7:0]  ram [16];

  alvio_write_ctrl_if rq ();

  alvio_write_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush_i),
    .req       (rq),
    .we_o      (we_o),
    .addrWr_o  (addrWr_o),
    .dataWr_o  (dataWr_o),
    .ready_o   (ready_o),
    .pending_o (pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] v;
    logic [3:0] a0;
    logic [7:0] d0;
    logic [3:0] a1;
    logic [7:0] d1;
    logic       fl;
    logic       ewe;
    logic [3:0] ea;
    logic [7:0] ed;
    logic [2:0] ep;
    logic       err;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(logic [1:0] v, logic [3:0] a0, logic [7:0] d0,
                              logic [3:0] a1, logic [7:0] d1, logic fl,
                              logic ewe, logic [3:0] ea, logic [7:0] ed,
                              logic [2:0] ep, logic err);
    vec_t r;
    r.v = v; r.a0 = a0; r.d0 = d0; r.a1 = a1; r.d1 = d1; r.fl = fl;
    r.ewe = ewe; r.ea = ea; r.ed = ed; r.ep = ep; r.err = err;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [3:0] a0, input logic [7:0] d0,
                       input logic [3:0] a1, input logic [7:0] d1, input logic fl);
    rq.reqValid_i   = v;
    rq.reqAddr_i[0] = a0;
    rq.reqData_i[0] = d0;
    rq.reqAddr_i[1] = a1;
    rq.reqData_i[1] = d1;
    flush_i         = fl;
  endtask

  // RAM model: records every write seen mid-cycle.
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = 8'hFF;
    forever begin
      @(negedge clk);
      if (we_o) begin
        ram[addrWr_o] = dataWr_o;
        if (track && dataWr_o != 8'h00) nz++;
      end
    end
  end

  initial begin
    vt[0]  = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[1]  = mk(2'd1, 4'h5, 8'h01, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[2]  = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 4'h5, 8'h01, 3'd1, 1'b1);
    vt[3]  = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[4]  = mk(2'd3, 4'h3, 8'h02, 4'h9, 8'h04, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[5]  = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 4'h3, 8'h02, 3'd2, 1'b1);
    vt[6]  = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 4'h9, 8'h04, 3'd1, 1'b1);
    vt[7]  = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[8]  = mk(2'd3, 4'hA, 8'h10, 4'hB, 8'h11, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[9]  = mk(2'd3, 4'hC, 8'h12, 4'hD, 8'h13, 1'b0, 1'b1, 4'hA, 8'h10, 3'd2, 1'b1);
    vt[10] = mk(2'd3, 4'hE, 8'h14, 4'hF, 8'h15, 1'b0, 1'b1, 4'hB, 8'h11, 3'd3, 1'b0);
    vt[11] = mk(2'd3, 4'hE, 8'h14, 4'hF, 8'h15, 1'b0, 1'b1, 4'hC, 8'h12, 3'd2, 1'b1);
    vt[12] = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 4'hD, 8'h13, 3'd3, 1'b0);
    vt[13] = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 4'hE, 8'h14, 3'd2, 1'b1);
    vt[14] = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b1, 4'hF, 8'h15, 3'd1, 1'b1);
    vt[15] = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[16] = mk(2'd3, 4'h1, 8'h21, 4'h2, 8'h22, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[17] = mk(2'd3, 4'h3, 8'h23, 4'h4, 8'h24, 1'b0, 1'b1, 4'h1, 8'h21, 3'd2, 1'b1);
    vt[18] = mk(2'd1, 4'h7, 8'h27, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 3'd3, 1'b0);
    vt[19] = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[20] = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[21] = mk(2'd1, 4'h8, 8'h28, 4'h0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);
    vt[22] = mk(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00, 3'd0, 1'b1);

    drive(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst.we",      32'(we_o),           32'd0);
    chk("rst.addr",    32'(addrWr_o),       32'd0);
    chk("rst.data",    32'(dataWr_o),       32'd0);
    chk("rst.ready",   32'(ready_o),        32'd0);
    chk("rst.reqRdy",  32'(rq.reqReady_o),  32'd0);
    chk("rst.pending", 32'(pending_o),      32'd0);

    // Init sweep, with requests and flush toggling that must be ignored.
    @(posedge clk);
    #1 reset = 1'b0;
    drive(2'd3, 4'h2, 8'hAA, 4'h2, 8'hBB, 1'b0);
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1 drive(2'd3, 4'h2, 8'hAA, 4'h2, 8'hBB, i[0]);
        #1;
      end
      chk($sformatf("init%0d.we", i),     32'(we_o),          32'd1);
      chk($sformatf("init%0d.addr", i),   32'(addrWr_o),      32'(i));
      chk($sformatf("init%0d.data", i),   32'(dataWr_o),      32'd0);
      chk($sformatf("init%0d.ready", i),  32'(ready_o),       32'd0);
      chk($sformatf("init%0d.reqRdy", i), 32'(rq.reqReady_o), 32'd0);
    end
    @(posedge clk);
    #1 drive(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
    #1;
    chk("init17.we",      32'(we_o),          32'd0);
    chk("init17.ready",   32'(ready_o),       32'd1);
    chk("init17.reqRdy",  32'(rq.reqReady_o), 32'd1);
    chk("init17.pending", 32'(pending_o),     32'd0);

    // Table-driven run-mode vectors.
    for (int i = 0; i < 23; i++) begin
      @(posedge clk);
      #1 drive(vt[i].v, vt[i].a0, vt[i].d0, vt[i].a1, vt[i].d1, vt[i].fl);
      #1;
      chk($sformatf("v%0d.we", i),      32'(we_o),          32'(vt[i].ewe));
      chk($sformatf("v%0d.pending", i), 32'(pending_o),     32'(vt[i].ep));
      chk($sformatf("v%0d.reqRdy", i),  32'(rq.reqReady_o), 32'(vt[i].err));
      chk($sformatf("v%0d.ready", i),   32'(ready_o),       32'd1);
      if (vt[i].ewe) begin
        chk($sformatf("v%0d.addr", i), 32'(addrWr_o), 32'(vt[i].ea));
        chk($sformatf("v%0d.data", i), 32'(dataWr_o), 32'(vt[i].ed));
      end
    end

    // RAM contents: drained writes landed, flushed requests never did.
    chk("ram5", 32'(ram[5]),  32'h01);
    chk("ram3", 32'(ram[3]),  32'h02);
    chk("ram9", 32'(ram[9]),  32'h04);
    chk("ramA", 32'(ram[10]), 32'h10);
    chk("ramF", 32'(ram[15]), 32'h15);
    chk("ram1", 32'(ram[1]),  32'h21);
    chk("ram2", 32'(ram[2]),  32'h00);
    chk("ram4", 32'(ram[4]),  32'h00);
    chk("ram7", 32'(ram[7]),  32'h00);
    chk("ram8", 32'(ram[8]),  32'h00);

    // Reset mid-run with two entries queued.
    @(posedge clk);
    #1 drive(2'd3, 4'h6, 8'h36, 4'h0, 8'h30, 1'b0);
    #1;
    chk("mid.reqRdy", 32'(rq.reqReady_o), 32'd1);
    @(posedge clk);
    #1 drive(2'd0, 4'h0, 8'h00, 4'h0, 8'h00, 1'b0);
    chk("mid.pendingPre", 32'(pending_o), 32'd2);
    reset = 1'b1;
    track = 1'b1;
    #1;
    chk("mid.ready",   32'(ready_o),       32'd0);
    chk("mid.we",      32'(we_o),          32'd0);
    chk("mid.addr",    32'(addrWr_o),      32'd0);
    chk("mid.data",    32'(dataWr_o),      32'd0);
    chk("mid.pending", 32'(pending_o),     32'd0);
    chk("mid.reqRdy",  32'(rq.reqReady_o), 32'd0);
    @(posedge clk);
    #1;
    chk("mid.weHeld", 32'(we_o), 32'd0);
    #1 reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #2;
      end
      chk($sformatf("resweep%0d.we", i),    32'(we_o),     32'd1);
      chk($sformatf("resweep%0d.addr", i),  32'(addrWr_o), 32'(i));
      chk($sformatf("resweep%0d.data", i),  32'(dataWr_o), 32'd0);
      chk($sformatf("resweep%0d.ready", i), 32'(ready_o),  32'd0);
    end
    @(posedge clk);
    #2;
    chk("resweep.done.ready",   32'(ready_o),   32'd1);
    chk("resweep.done.we",      32'(we_o),      32'd0);
    chk("resweep.done.pending", 32'(pending_o), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    chk("resweep.staleWrites", 32'(nz), 32'd0);
    chk("resweep.idleWe",      32'(we_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alvio_write_ctrl.md
# alvio_write_ctrl

Write-side controller for the active-list violation RAM. Accepts violation-bit update requests from the load/store disambiguation logic on up to `NUM_REQ` lanes per cycle and buffers them in a small in-order queue. Drains the queue through the RAM's single write port. After every reset it first sweeps the whole RAM to zero, and only then raises `ready_o`, which drives the core's AL-violation ready indication.

## Interface
- `DEPTH`, 16, active-list entries (RAM depth)
- `INDEX`, 4, log2(`DEPTH`)
- `WIDTH`, 8, violation-record width
- `NUM_REQ`, 2, request lanes per cycle
- `Q_DEPTH`, 4, request queue entries (power of two, ≥ `NUM_REQ`)
- `Q_LOG`, 2, log2(`Q_DEPTH`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `flush_i`  in  1  pipeline recovery; discard all queued and same-cycle requests
- `reqValid_i`  in  `NUM_REQ`  per-lane request valid
- `reqAddr_i`  in  `NUM_REQ`×`INDEX`  AL index per lane
- `reqData_i`  in  `NUM_REQ`×`WIDTH`  violation record per lane
- `reqReady_o`  out  1  all lanes may push this cycle
- `we_o`  out  1  RAM write enable
- `addrWr_o`  out  `INDEX`  RAM write address
- `dataWr_o`  out  `WIDTH`  RAM write data
- `ready_o`  out  1  init sweep complete
- `pending_o`  out  `Q_LOG`+1  queue occupancy

## Operation
- **States:** `ALVIO_INIT`, `ALVIO_RUN`.
- **Asynchronous reset** forces:
  - state = `ALVIO_INIT`, sweep counter = 0
  - queue empty, `pending_o` = 0
  - `ready_o` = 0, `reqReady_o` = 0
- **While `reset` is high:** `we_o` = 0, `addrWr_o` = 0, `dataWr_o` = 0.
- **`ALVIO_INIT`:**
  - Each cycle: `we_o` = 1, `addrWr_o` = counter, `dataWr_o` = 0.
  - Counter increments by 1.
  - On the cycle that writes `DEPTH`-1, next state = `ALVIO_RUN`.
  - `flush_i` and `reqValid_i` are ignored.
- **`ALVIO_RUN`:**
  - `ready_o` = 1.
  - `we_o`/`addrWr_o`/`dataWr_o` are driven combinationally from the queue head: `we_o` = queue non-empty AND NOT `flush_i`.
  - When `we_o` = 1, the head pops at the clock edge.
- **Accept rule:**
  - `reqReady_o` = RUN AND (`Q_DEPTH` − `pending_o`) ≥ `NUM_REQ`, computed from the registered count only (no credit for a same-cycle pop).
  - A lane is pushed when `reqValid_i[k]` AND `reqReady_o` AND NOT `flush_i`.
  - Senders hold requests while `reqReady_o` = 0.
- **Ordering:** same-cycle pushes enter the queue in lane order 0..`NUM_REQ`-1. Same-address requests are not merged; the later write wins in the RAM.
- **Occupancy:** `pending_o`' = `pending_o` + pushes − pop. Pointers wrap modulo `Q_DEPTH`; full = `pending_o` == `Q_DEPTH`.
- **Flush:** on a `flush_i` cycle:
  - `we_o` = 0, no pushes, no pop.
  - Next cycle `pending_o` = 0 and pointers equal.
- **Reset mid-operation:** queued requests are lost, and the sweep restarts from index 0 after deassertion.

## Timing
- The first sweep write occurs on the first cycle after `reset` deasserts.
- `ready_o` rises `DEPTH` cycles after deassertion.
- Push at cycle t into an empty queue → `we_o` at t+1 → RAM updated at the t+1 edge.
- Drain rate is 1 write/cycle. Throughput is limited by the single write port; backpressure is via `reqReady_o`.
- All state is registered. Outputs are combinational from registered state plus `flush_i`/`reset`.

## Structure
- **Shared package:**
  - `alvio_wr_state_t` enum {`ALVIO_INIT`, `ALVIO_RUN`}
  - `alvioReq_t` struct {addr[`INDEX`], data[`WIDTH`]}
- **Sub-module `alvio_req_fifo`:** `NUM_REQ` push ports, 1 pop port, synchronous clear, async reset. It holds the pointers and count.
- **Top level:** FSM, sweep counter, output mux.

## Test plan
- **Init sweep:** deassert reset → 16 cycles with `we_o` = 1, `addrWr_o` = 0..15, `dataWr_o` = 0, `ready_o` = 0. Cycle 17: `we_o` = 0, `ready_o` = 1, `reqReady_o` = 1.
- **Single request:** lane0 addr 5, data 0x01 at t → `we_o` = 1, addr 5, data 0x01 at t+1 only. `pending_o` = 1 at t+1, 0 at t+2.
- **Dual-lane ordering:** lane0 (3, 0x02) and lane1 (9, 0x04) at t → writes addr 3 at t+1, then addr 9 at t+2.
- **Backpressure:** 2 requests/cycle starting at t.
  - `pending_o` = 2 at t+1 and 3 at t+2.
  - `reqReady_o` = 0 at t+2 and returns to 1 once `pending_o` ≤ 2.
  - No request is lost or reordered.
- **Flush:** 3 entries queued plus a lane0 request with `flush_i` = 1 → `we_o` = 0 that cycle. Next cycle `pending_o` = 0, `we_o` = 0. The flushed request is never written.
- **Reset mid-run:** assert reset with 2 entries queued → `ready_o` = 0 and `we_o` = 0 immediately. After deassertion a full 16-cycle sweep runs, and the old entries are never written.
